axi_mem_slave: RTL and testbench

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_pkg.sv | 43 ++++
 rtl/axi_mem_addr_gen.sv | 51 +++++
 rtl/axi_mem_slave.sv | 273 +++++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 widths, burst/response encodings, request payload and
// FSM state types for the axi_mem_slave codebase slice.
package axi_pkg;

   localparam int unsigned AXI_ID_WIDTH   = 4;
   localparam int unsigned AXI_ADDR_WIDTH = 32;
   localparam int unsigned AXI_DATA_WIDTH = 64;
   localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } axi_burst_e;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } axi_resp_e;

   // Captured address-channel request; burst kept raw so reserved codes survive.
   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                size;
      logic [1:0]                burst;
   } axi_req_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

endpackage

// File: rtl/axi_mem_addr_gen.sv
// axi_mem_addr_gen: combinational next-beat address for one AXI burst.
// Inputs : addr, size, len, burst of the current beat.
// Outputs: next_addr (address of the following beat), illegal (burst gets SLVERR).
// Macro  : AXI_MEM_SLAVE_WRAP_EN enables WRAP bursts; otherwise WRAP is reserved.
module axi_mem_addr_gen
   import axi_pkg::*;
(
   input  logic [AXI_ADDR_WIDTH-1:0] addr,
   input  logic [2:0]                size,
   input  logic [7:0]                len,
   input  logic [1:0]                burst,
   output logic [AXI_ADDR_WIDTH-1:0] next_addr,
   output logic                      illegal
);

   logic [AXI_ADDR_WIDTH-1:0] step;

   assign step = AXI_ADDR_WIDTH'(1) << size;

`ifdef AXI_MEM_SLAVE_WRAP_EN
   // Byte offset mask of the wrap window: (len+1) * 2^size bytes.
   logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
   logic                      wrap_len_ok;

   assign wrap_mask   = ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size) - AXI_ADDR_WIDTH'(1);
   assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
`else
   logic unused_len;
   assign unused_len = ^len;
`endif

   always_comb begin
      next_addr = addr;
      illegal   = 1'b0;
      case (burst)
         FIXED: next_addr = addr;
         INCR:  next_addr = addr + step;
`ifdef AXI_MEM_SLAVE_WRAP_EN
         WRAP: begin
            if (wrap_len_ok) begin
               next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            end else begin
               illegal = 1'b1;
            end
         end
`endif
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 slave backed by a MEM_DEPTH x AXI_DATA_WIDTH memory.
// Ports: ACLK, ARESETn (sync, active-low); AW/W/B write channels; AR/R read
//        channels. Lock/cache/prot/qos/region and WID are accepted but unused.
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs.
// Macro: AXI_MEM_SLAVE_WRAP_EN enables WRAP bursts (see axi_mem_addr_gen).
module axi_mem_slave
   import axi_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 1024
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  logic [AXI_ID_WIDTH-1:0]   AWID,
   input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
   input  logic [7:0]                AWLEN,
   input  logic [2:0]                AWSIZE,
   input  logic [1:0]                AWBURST,
   input  logic [1:0]                AWLOCK,
   input  logic [3:0]                AWCACHE,
   input  logic [2:0]                AWPROT,
   input  logic [3:0]                AWQOS,
   input  logic [3:0]                AWREGION,
   input  logic                      AWVALID,
   output logic                      AWREADY,
   input  logic [AXI_ID_WIDTH-1:0]   WID,
   input  logic [AXI_DATA_WIDTH-1:0] WDATA,
   input  logic [AXI_STRB_WIDTH-1:0] WSTRB,
   input  logic                      WLAST,
   input  logic                      WVALID,
   output logic                      WREADY,
   output logic [AXI_ID_WIDTH-1:0]   BID,
   output logic [1:0]                BRESP,
   output logic                      BVALID,
   input  logic                      BREADY,
   input  logic [AXI_ID_WIDTH-1:0]   ARID,
   input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
   input  logic [7:0]                ARLEN,
   input  logic [2:0]                ARSIZE,
   input  logic [1:0]                ARBURST,
   input  logic [1:0]                ARLOCK,
   input  logic [3:0]                ARCACHE,
   input  logic [2:0]                ARPROT,
   input  logic [3:0]                ARQOS,
   input  logic [3:0]                ARREGION,
   input  logic                      ARVALID,
   output logic                      ARREADY,
   output logic [AXI_ID_WIDTH-1:0]   RID,
   output logic [AXI_DATA_WIDTH-1:0] RDATA,
   output logic [1:0]                RRESP,
   output logic                      RLAST,
   output logic                      RVALID,
   input  logic                      RREADY
);

   localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
   localparam int unsigned IDX_LSB = $clog2(AXI_STRB_WIDTH);

   logic unused_inputs;
   assign unused_inputs = ^{AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION,
                            ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, WID};

   // Byte address to word index; upper bits drop so the index wraps at MEM_DEPTH.
   function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
      return IDX_W'(a >> IDX_LSB);
   endfunction

   logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // ---------------- write channel ----------------
   w_state_e                  w_state, w_state_d;
   axi_req_t                  aw_req, w_req, w_req_d;
   logic [7:0]                w_cnt, w_cnt_d;
   logic                      w_err, w_err_d, mem_we;
   logic                      awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [AXI_ID_WIDTH-1:0]   bid_q, bid_d;
   logic [1:0]                bresp_q, bresp_d;
   logic [AXI_ADDR_WIDTH-1:0] w_next;
   logic                      w_illegal;

   assign aw_req = '{id: AWID, addr: AWADDR, len: AWLEN, size: AWSIZE, burst: AWBURST};

   axi_mem_addr_gen u_wr_gen (
      .addr      (w_req.addr),
      .size      (w_req.size),
      .len       (w_req.len),
      .burst     (w_req.burst),
      .next_addr (w_next),
      .illegal   (w_illegal)
   );

   // Write FSM next state and registered-output next values.
   always_comb begin
      w_state_d = w_state;
      w_req_d   = w_req;
      w_cnt_d   = w_cnt;
      w_err_d   = w_err;
      mem_we    = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (AWVALID && awready_q) begin
               w_req_d   = aw_req;
               w_cnt_d   = '0;
               w_err_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (WVALID && wready_q) begin
               mem_we = !w_illegal && ARESETn;
               // Error is sticky: a bad WLAST or illegal burst taints the whole response.
               if ((WLAST != (w_cnt == w_req.len)) || w_illegal) w_err_d = 1'b1;
               w_req_d.addr = w_next;
               w_cnt_d      = w_cnt + 8'd1;
               if (w_cnt == w_req.len) w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (BREADY && bvalid_q) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
      bid_d     = bvalid_d ? w_req_d.id : '0;
      bresp_d   = bvalid_d ? (w_err_d ? 2'(SLVERR) : 2'(OKAY)) : 2'(OKAY);
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         w_state   <= W_IDLE;
         w_req     <= '0;
         w_cnt     <= '0;
         w_err     <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= '0;
      end else begin
         w_state   <= w_state_d;
         w_req     <= w_req_d;
         w_cnt     <= w_cnt_d;
         w_err     <= w_err_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
      end
   end

   // Byte-strobed memory write; contents are deliberately never reset.
   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         for (int b = 0; b < int'(AXI_STRB_WIDTH); b++) begin
            if (WSTRB[b]) mem[word_idx(w_req.addr)][8*b +: 8] <= WDATA[8*b +: 8];
         end
      end
   end

   // ---------------- read channel ----------------
   r_state_e                  r_state, r_state_d;
   axi_req_t                  ar_req, r_req, r_req_d;
   logic [7:0]                r_cnt, r_cnt_d;
   logic                      arready_q, arready_d, rvalid_q, rvalid_d;
   logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]                rresp_q, rresp_d;
   logic                      rlast_q, rlast_d;
   logic [AXI_ADDR_WIDTH-1:0] r_gen_addr, r_next;
   logic [7:0]                r_gen_len;
   logic [2:0]                r_gen_size;
   logic [1:0]                r_gen_burst;
   logic                      r_illegal;

   assign ar_req = '{id: ARID, addr: ARADDR, len: ARLEN, size: ARSIZE, burst: ARBURST};

   // In idle the generator judges the incoming AR so beat 0 already knows legality.
   assign r_gen_addr  = (r_state == R_IDLE) ? ARADDR  : r_req.addr;
   assign r_gen_len   = (r_state == R_IDLE) ? ARLEN   : r_req.len;
   assign r_gen_size  = (r_state == R_IDLE) ? ARSIZE  : r_req.size;
   assign r_gen_burst = (r_state == R_IDLE) ? ARBURST : r_req.burst;

   axi_mem_addr_gen u_rd_gen (
      .addr      (r_gen_addr),
      .size      (r_gen_size),
      .len       (r_gen_len),
      .burst     (r_gen_burst),
      .next_addr (r_next),
      .illegal   (r_illegal)
   );

   // Read FSM next state; RDATA is fetched one beat ahead so it is ready with RVALID.
   always_comb begin
      r_state_d = r_state;
      r_req_d   = r_req;
      r_cnt_d   = r_cnt;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      case (r_state)
         R_IDLE: begin
            if (ARVALID && arready_q) begin
               r_req_d   = ar_req;
               r_cnt_d   = '0;
               r_state_d = R_DATA;
               rid_d     = ARID;
               rdata_d   = r_illegal ? '0 : mem[word_idx(ARADDR)];
               rresp_d   = r_illegal ? 2'(SLVERR) : 2'(OKAY);
               rlast_d   = (ARLEN == 8'd0);
            end
         end
         R_DATA: begin
            if (RREADY && rvalid_q) begin
               if (rlast_q) begin
                  r_state_d = R_IDLE;
                  rid_d     = '0;
                  rdata_d   = '0;
                  rresp_d   = '0;
                  rlast_d   = 1'b0;
               end else begin
                  r_req_d.addr = r_next;
                  r_cnt_d      = r_cnt + 8'd1;
                  rdata_d      = r_illegal ? '0 : mem[word_idx(r_next)];
                  rlast_d      = (r_cnt_d == r_req.len);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_state   <= R_IDLE;
         r_req     <= '0;
         r_cnt     <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rlast_q   <= 1'b0;
      end else begin
         r_state   <= r_state_d;
         r_req     <= r_req_d;
         r_cnt     <= r_cnt_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
      end
   end

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BID     = bid_q;
   assign BRESP   = bresp_q;
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RID     = rid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed stimulus with a queue scoreboard; a negedge
// monitor checks every B and R handshake against the expected queues.
module tb_axi_mem_slave;
   import axi_pkg::*;

   localparam int LIM = 200;

   logic                      ACLK = 1'b0;
   logic                      ARESETn = 1'b0;
   logic [AXI_ID_WIDTH-1:0]   AWID = '0, WID = '0, ARID = '0;
   logic [AXI_ADDR_WIDTH-1:0] AWADDR = '0, ARADDR = '0;
   logic [7:0]                AWLEN = '0, ARLEN = '0;
   logic [2:0]                AWSIZE = '0, ARSIZE = '0, AWPROT = '0, ARPROT = '0;
   logic [1:0]                AWBURST = '0, ARBURST = '0, AWLOCK = '0, ARLOCK = '0;
   logic [3:0]                AWCACHE = '0, AWQOS = '0, AWREGION = '0;
   logic [3:0]                ARCACHE = '0, ARQOS = '0, ARREGION = '0;
   logic                      AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0, ARVALID = 1'b0;
   logic                      BREADY = 1'b1, RREADY = 1'b1;
   logic [AXI_DATA_WIDTH-1:0] WDATA = '0;
   logic [AXI_STRB_WIDTH-1:0] WSTRB = '0;
   logic                      AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
   logic [AXI_ID_WIDTH-1:0]   BID, RID;
   logic [1:0]                BRESP, RRESP;
   logic [AXI_DATA_WIDTH-1:0] RDATA;

   axi_mem_slave #(.MEM_DEPTH(1024)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
      .AWREGION(AWREGION), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
      .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      logic [1:0]              resp;
   } exp_b_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [1:0]                resp;
      logic                      last;
   } exp_r_t;

   exp_b_t exp_b[$];
   exp_r_t exp_r[$];
   int     checks = 0;
   int     errors = 0;
   logic   mon_en = 1'b0;
   logic [AXI_DATA_WIDTH-1:0] wbuf [16];
   logic [AXI_DATA_WIDTH-1:0] ebuf [16];

   function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endfunction

   // Scoreboard monitor: handshakes seen at negedge complete on the next posedge.
   always @(negedge ACLK) begin
      if (mon_en) begin
         if (BVALID === 1'b1 && BREADY) begin
            checks++;
            if (exp_b.size() == 0) begin
               errors++;
               $display("FAIL b_unexpected actual=id%h/resp%h required=none", BID, BRESP);
            end else begin
               exp_b_t e;
               e = exp_b.pop_front();
               checks--;
               chk("b_resp", 96'({BID, BRESP}), 96'({e.id, e.resp}));
            end
         end else if (BVALID === 1'b0) begin
            chk("b_idle_zero", 96'({BID, BRESP}), 96'(0));
         end
         if (RVALID === 1'b1 && RREADY) begin
            checks++;
            if (exp_r.size() == 0) begin
               errors++;
               $display("FAIL r_unexpected actual=id%h/data%h required=none", RID, RDATA);
            end else begin
               exp_r_t e;
               e = exp_r.pop_front();
               checks--;
               chk("r_beat", 96'({RID, RDATA, RRESP, RLAST}), 96'({e.id, e.data, e.resp, e.last}));
            end
         end else if (RVALID === 1'b0) begin
            chk("r_idle_zero", 96'({RID, RDATA, RRESP, RLAST}), 96'(0));
         end
      end
   end

   task automatic wait_drain();
      int n = 0;
      while ((exp_b.size() != 0 || exp_r.size() != 0) && n < LIM) begin
         @(posedge ACLK);
         n++;
      end
      chk("drain", 96'({exp_b.size() == 0, exp_r.size() == 0}), 96'(3));
      #1;
   endtask

   // Write burst from wbuf; WLAST asserted on beat index last_beat.
   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [7:0] strb, input int last_beat,
                           input logic [1:0] resp);
      int n;
      exp_b.push_back('{id: id, resp: resp});
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd3; AWBURST = burst; AWVALID = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end while (!AWREADY && n < LIM);
      chk("awready_wait", 96'(AWREADY), 96'(1));
      @(posedge ACLK); #1;
      AWVALID = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         WDATA = wbuf[i]; WSTRB = strb; WLAST = (i == last_beat); WVALID = 1'b1;
         n = 0;
         do begin @(negedge ACLK); n++; end while (!WREADY && n < LIM);
         if (i == 0) chk("wready_latency", 96'(n), 96'(1));
         else chk("wready_wait", 96'(WREADY), 96'(1));
         @(posedge ACLK); #1;
      end
      WVALID = 1'b0; WLAST = 1'b0;
      wait_drain();
   endtask

   // Issue AR; ends at posedge+1 one cycle after the handshake.
   task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
      int n;
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd3; ARBURST = burst; ARVALID = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end while (!ARREADY && n < LIM);
      chk("arready_wait", 96'(ARREADY), 96'(1));
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      @(negedge ACLK);
      chk("rvalid_latency", 96'(RVALID), 96'(1));
      @(posedge ACLK); #1;
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [1:0] resp);
      for (int i = 0; i <= int'(len); i++)
         exp_r.push_back('{id: id, data: ebuf[i], resp: resp, last: (i == int'(len))});
      ar_send(id, addr, len, burst);
      wait_drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: everything low while held.
      repeat (3) @(posedge ACLK);
      #1;
      @(negedge ACLK);
      chk("reset_outputs", 96'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RRESP, RLAST}), 96'(0));
      chk("reset_rdata", 96'(RDATA), 96'(0));
      mon_en = 1'b1;
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("ready_after_reset", 96'({AWREADY, ARREADY, WREADY}), 96'(3'b110));
      @(posedge ACLK); #1;

      // INCR write and read-back.
      wbuf[0] = 64'hA000_0000_0000_00A0; wbuf[1] = 64'hA100_0000_0000_00A1;
      wbuf[2] = 64'hA200_0000_0000_00A2; wbuf[3] = 64'hA300_0000_0000_00A3;
      do_write(4'h5, 32'h100, 8'd3, 2'd1, 8'hFF, 3, 2'd0);
      for (int i = 0; i < 4; i++) ebuf[i] = wbuf[i];
      do_read(4'h6, 32'h100, 8'd3, 2'd1, 2'd0);

      // Byte strobe: only byte 0 updates over all-ones.
      wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      do_write(4'h1, 32'h200, 8'd0, 2'd1, 8'hFF, 0, 2'd0);
      wbuf[0] = 64'h0123_4567_89AB_CDEF;
      do_write(4'h2, 32'h200, 8'd0, 2'd1, 8'h01, 0, 2'd0);
      ebuf[0] = 64'hFFFF_FFFF_FFFF_FFEF;
      do_read(4'h3, 32'h200, 8'd0, 2'd1, 2'd0);

      // Early WLAST on a 2-beat burst gives SLVERR.
      wbuf[0] = 64'hB0; wbuf[1] = 64'hB1;
      do_write(4'h4, 32'h300, 8'd1, 2'd1, 8'hFF, 0, 2'd2);

      // R outputs held stable while RREADY is low.
      RREADY = 1'b0;
      for (int i = 0; i < 4; i++)
         exp_r.push_back('{id: 4'h7, data: 64'hA000_0000_0000_00A0 | (64'(i) << 56) | 64'(i),
                           resp: 2'd0, last: (i == 3)});
      ar_send(4'h7, 32'h100, 8'd3, 2'd1);
      repeat (5) begin
         @(negedge ACLK);
         chk("r_hold", 96'({RVALID, RID, RDATA, RRESP, RLAST}),
             96'({1'b1, 4'h7, 64'hA000_0000_0000_00A0, 2'd0, 1'b0}));
      end
      @(posedge ACLK); #1;
      RREADY = 1'b1;
      wait_drain();

      // WRAP burst over a preloaded 32-byte window.
      wbuf[0] = 64'hD0; wbuf[1] = 64'hD1; wbuf[2] = 64'hD2; wbuf[3] = 64'hD3;
      do_write(4'h9, 32'h0, 8'd3, 2'd1, 8'hFF, 3, 2'd0);
      wbuf[0] = 64'hC0; wbuf[1] = 64'hC1; wbuf[2] = 64'hC2; wbuf[3] = 64'hC3;
`ifdef AXI_MEM_SLAVE_WRAP_EN
      do_write(4'hA, 32'h18, 8'd3, 2'd2, 8'hFF, 3, 2'd0);
      ebuf[0] = 64'hC1; ebuf[1] = 64'hC2; ebuf[2] = 64'hC3; ebuf[3] = 64'hC0;
      do_read(4'hB, 32'h0, 8'd3, 2'd1, 2'd0);
      ebuf[0] = 64'hC0; ebuf[1] = 64'hC1; ebuf[2] = 64'hC2; ebuf[3] = 64'hC3;
      do_read(4'hC, 32'h18, 8'd3, 2'd2, 2'd0);
`else
      do_write(4'hA, 32'h18, 8'd3, 2'd2, 8'hFF, 3, 2'd2);
      ebuf[0] = 64'hD0; ebuf[1] = 64'hD1; ebuf[2] = 64'hD2; ebuf[3] = 64'hD3;
      do_read(4'hB, 32'h0, 8'd3, 2'd1, 2'd0);
      for (int i = 0; i < 4; i++) ebuf[i] = '0;
      do_read(4'hC, 32'h18, 8'd3, 2'd2, 2'd2);
`endif
      // WRAP with a length of 3 beats is illegal in every build.
      for (int i = 0; i < 3; i++) ebuf[i] = '0;
      do_read(4'hD, 32'h0, 8'd2, 2'd2, 2'd2);

      // Reserved burst type: write ignored, read returns zeros with SLVERR.
      wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF;
      do_write(4'hE, 32'h100, 8'd0, 2'd3, 8'hFF, 0, 2'd2);
      ebuf[0] = '0; ebuf[1] = '0;
      do_read(4'hF, 32'h100, 8'd1, 2'd3, 2'd2);
      ebuf[0] = 64'hA000_0000_0000_00A0;
      do_read(4'h2, 32'h100, 8'd0, 2'd1, 2'd0);

      // FIXED burst: all beats land on one word.
      wbuf[0] = 64'hE0; wbuf[1] = 64'hE1; wbuf[2] = 64'hE2;
      do_write(4'h1, 32'h400, 8'd2, 2'd0, 8'hFF, 2, 2'd0);
      ebuf[0] = 64'hE2; ebuf[1] = 64'hE2;
      do_read(4'h3, 32'h400, 8'd1, 2'd0, 2'd0);

      // Word index wraps at MEM_DEPTH (last word then word 0).
      wbuf[0] = 64'hF0; wbuf[1] = 64'hF1;
      do_write(4'h4, 32'h1FF8, 8'd1, 2'd1, 8'hFF, 1, 2'd0);
      ebuf[0] = 64'hF0; ebuf[1] = 64'hF1;
      do_read(4'h5, 32'h1FF8, 8'd1, 2'd1, 2'd0);
      ebuf[0] = 64'hF1;
      do_read(4'h6, 32'h0, 8'd0, 2'd1, 2'd0);

      // Reset during beat 2 of a 4-beat read abandons the burst.
      RREADY = 1'b0;
      exp_r.push_back('{id: 4'h9, data: 64'hA000_0000_0000_00A0, resp: 2'd0, last: 1'b0});
      ar_send(4'h9, 32'h100, 8'd3, 2'd1);
      RREADY = 1'b1;
      @(posedge ACLK); #1;
      RREADY = 1'b0;
      ARESETn = 1'b0;
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("rvalid_after_reset", 96'({RVALID, ARREADY, AWREADY}), 96'(0));
      @(posedge ACLK); #1;
      RREADY = 1'b1;
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("arready_after_release", 96'({ARREADY, RVALID}), 96'(2'b10));
      repeat (5) @(posedge ACLK);
      #1;
      chk("no_pending", 96'({exp_b.size() == 0, exp_r.size() == 0}), 96'(3));

      // Memory survives reset.
      ebuf[0] = 64'hA100_0000_0000_00A1;
      do_read(4'h8, 32'h108, 8'd0, 2'd1, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
